// File: rtl/sar_adc_ctrl_if.sv
// Control/readout bus of the SAR ADC controller: conversion request in, result out.
interface sar_adc_ctrl_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SETTLE_W = 12
);
  logic                start;
  logic                cont;
  logic [SETTLE_W-1:0] settle;
  logic                busy;
  logic                valid;
  logic [WIDTH-1:0]    result;

  // Requester side: launches conversions and captures results
  modport master (
    output start, cont, settle,
    input  busy, valid, result
  );

  // Controller side
  modport slave (
    input  start, cont, settle,
    output busy, valid, result
  );
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: walks trial codes on the R2R DAC from
// the MSB down, keeping each bit the synchronised comparator says is not too high.
module sar_adc_ctrl #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SETTLE_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  sar_adc_ctrl_if.slave    bus,
  input  logic             comp,
  output logic [WIDTH-1:0] dac_code
);

  localparam int unsigned        IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0]   IDX_MSB  = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   CODE_MSB = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DECIDE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]    dac_code_q, dac_code_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                comp_meta_q, comp_s_q;
  logic [WIDTH-1:0]    dec_code;

  // Two-flop synchroniser for the asynchronous comparator output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      comp_meta_q <= 1'b0;
      comp_s_q    <= 1'b0;
    end else begin
      comp_meta_q <= comp;
      comp_s_q    <= comp_meta_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= IDX_MSB;
      cnt_q      <= '0;
      dac_code_q <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      dac_code_q <= dac_code_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state logic: launch, per-bit settle wait, and bit decision
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    dac_code_d = dac_code_q;
    result_d   = result_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;

    // Current trial with the bit under test dropped if the DAC overshot vin
    dec_code = dac_code_q;
    if (!comp_s_q) dec_code[idx_q] = 1'b0;

    case (state_q)
      IDLE: begin
        dac_code_d = result_q;
        busy_d     = 1'b0;
        if (bus.start) begin
          dac_code_d = CODE_MSB;
          idx_d      = IDX_MSB;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = SETTLE;
        end
      end

      SETTLE: begin
        if (cnt_q == bus.settle) begin
          cnt_d   = '0;
          state_d = DECIDE;
        end else begin
          cnt_d = cnt_q + SETTLE_W'(1);
        end
      end

      DECIDE: begin
        if (idx_q != '0) begin
          dac_code_d                      = dec_code;
          dac_code_d[idx_q - IDX_W'(1)]   = 1'b1;
          idx_d                           = idx_q - IDX_W'(1);
          state_d                         = SETTLE;
        end else begin
          result_d = dec_code;
          valid_d  = 1'b1;
          if (bus.cont) begin
            dac_code_d = CODE_MSB;
            idx_d      = IDX_MSB;
            state_d    = SETTLE;
          end else begin
            dac_code_d = dec_code;
            busy_d     = 1'b0;
            state_d    = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign dac_code   = dac_code_q;
  assign bus.busy   = busy_q;
  assign bus.valid  = valid_q;
  assign bus.result = result_q;

endmodule
